// File: rtl/port_cache_pkg.sv
// Shared types and helpers for the output-port responder and its cache write path.
package port_cache_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE     = 2'd0;
  localparam state_t S_WAIT_SOP = 2'd1;
  localparam state_t S_RECV     = 2'd2;

  localparam int BLOCK_BYTES = 64;
  localparam int HDR_LEN_MSB = 16;
  localparam int HDR_LEN_LSB = 7;
  localparam int HDR_LEN_W   = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  // Header length field to 64-byte blocks, rounded up with a 4-byte slack, in 11 bits.
  function automatic logic [10:0] blocks_needed(input logic [HDR_LEN_W-1:0] len);
    logic [10:0] sum;
    sum = 11'(len) + 11'd4;
    return (sum >> $clog2(BLOCK_BYTES)) + 11'd1;
  endfunction

endpackage

// File: rtl/rr_arb16.sv
// Round-robin one-hot picker: first request at or after the pointer, with wrap.
// Pointer advances past the winner only when the caller takes the grant. N must be a power of two.
module rr_arb16 #(
  parameter int N = 16,
  localparam int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_take,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = ptr_q + IW'(i);
      if (!o_vld && i_req[k]) begin
        o_vld    = 1'b1;
        o_idx    = k;
        o_gnt[k] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (i_take && o_vld) begin
      ptr_d = o_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/port_resp_arb.sv
// Output-port responder: grants one channel, forwards its packet to the cache, tracks free blocks.
// Build option PORT_RESP_TIMEOUT_EN adds a grant-to-header timeout and the o_timeout port.
//
// state      | meaning
// S_IDLE     | free, arbitrating incoming requests
// S_WAIT_SOP | granted, waiting for the winner's header beat
// S_RECV     | forwarding payload beats until eop
module port_resp_arb
  import port_cache_pkg::*;
#(
  parameter int PORTNUM    = 16,
  parameter int DWIDTH     = 32,
  parameter int RAMWIDTH   = 10,
  parameter int RAM_BLOCKS = 1023,
  parameter int TIMEOUT    = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
`ifdef PORT_RESP_TIMEOUT_EN
  output logic                o_timeout,
`endif
  input  logic [PORTNUM-1:0]  i_req,
  output logic [PORTNUM-1:0]  o_resp,
  output logic [PORTNUM-1:0]  o_nresp,
  input  logic [DWIDTH-1:0]   i_data [PORTNUM-1:0],
  input  logic [PORTNUM-1:0]  i_data_vld,
  input  logic [PORTNUM-1:0]  i_eop,
  output logic                o_ready,
  output logic [RAMWIDTH-1:0] o_ramspace,
  output logic                o_wr_en,
  output logic [DWIDTH-1:0]   o_wr_data,
  output logic                o_wr_sop,
  output logic                o_wr_eop,
  input  logic                i_free_vld,
  input  logic [RAMWIDTH-1:0] i_free_blocks
);

  localparam int SW = $clog2(PORTNUM);
  localparam logic [RAMWIDTH:0] MAX_SPACE = (RAMWIDTH+1)'(RAM_BLOCKS);

  state_t               state_q, state_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic [PORTNUM-1:0]   resp_q, resp_d;
  logic [PORTNUM-1:0]   nresp_q, nresp_d;
  logic                 wr_en_q, wr_en_d;
  logic [DWIDTH-1:0]    wr_data_q, wr_data_d;
  logic                 wr_sop_q, wr_sop_d;
  logic                 wr_eop_q, wr_eop_d;
  logic                 ready_q, ready_d;
  logic [RAMWIDTH-1:0]  space_q, space_d;

  logic [PORTNUM-1:0]   arb_gnt;
  logic [SW-1:0]        arb_idx;
  logic                 arb_vld;
  logic                 arb_take;

  logic [DWIDTH-1:0]    sel_data;
  logic                 beat;
  logic                 last;
  logic                 tmo_expire;
  logic [RAMWIDTH-1:0]  reserve;
  logic [RAMWIDTH:0]    free_add;
  logic [RAMWIDTH:0]    space_sum;
  logic [RAMWIDTH:0]    space_net;
  logic                 space_underflow;

  assign arb_take = (state_q == S_IDLE);

  rr_arb16 #(
    .N (PORTNUM)
  ) u_rr_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req),
    .i_take  (arb_take),
    .o_gnt   (arb_gnt),
    .o_idx   (arb_idx),
    .o_vld   (arb_vld)
  );

  assign sel_data = i_data[sel_q];
  assign beat     = i_data_vld[sel_q];
  assign last     = i_eop[sel_q];

`ifdef PORT_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;

  // Down-counter loaded at grant; the last allowed S_WAIT_SOP cycle is when it reads 1.
  assign tmo_expire = (state_q == S_WAIT_SOP) && !beat && (tmo_cnt_q == TW'(1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = tmo_expire;
    if (state_q == S_IDLE && arb_vld) begin
      tmo_cnt_d = TW'(TIMEOUT);
    end else if (state_q == S_WAIT_SOP && tmo_cnt_q != '0) begin
      tmo_cnt_d = tmo_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    resp_d    = '0;
    nresp_d   = '0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_sop_d  = 1'b0;
    wr_eop_d  = 1'b0;
    reserve   = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          resp_d  = arb_gnt;
          nresp_d = i_req & ~arb_gnt;
          sel_d   = arb_idx;
          state_d = S_WAIT_SOP;
        end
      end
      S_WAIT_SOP: begin
        nresp_d = i_req;
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_sop_d  = 1'b1;
          wr_eop_d  = last;
          wr_data_d = sel_data;
          reserve   = RAMWIDTH'(blocks_needed(sel_data[HDR_LEN_MSB:HDR_LEN_LSB]));
          state_d   = last ? S_IDLE : S_RECV;
        end else if (tmo_expire) begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        nresp_d = i_req;
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_eop_d  = last;
          wr_data_d = sel_data;
          if (last) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reservation and release net out in one update, clamped to [0, RAM_BLOCKS].
  always_comb begin
    free_add        = i_free_vld ? {1'b0, i_free_blocks} : '0;
    space_sum       = {1'b0, space_q} + free_add;
    space_underflow = (space_sum < {1'b0, reserve});
    space_net       = space_sum - {1'b0, reserve};
    if (space_underflow) begin
      space_d = '0;
    end else if (space_net > MAX_SPACE) begin
      space_d = MAX_SPACE[RAMWIDTH-1:0];
    end else begin
      space_d = space_net[RAMWIDTH-1:0];
    end
    ready_d = (state_d == S_IDLE) && (space_d != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      resp_q    <= '0;
      nresp_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_sop_q  <= 1'b0;
      wr_eop_q  <= 1'b0;
      ready_q   <= 1'b1;
      space_q   <= MAX_SPACE[RAMWIDTH-1:0];
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      resp_q    <= resp_d;
      nresp_q   <= nresp_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_sop_q  <= wr_sop_d;
      wr_eop_q  <= wr_eop_d;
      ready_q   <= ready_d;
      space_q   <= space_d;
    end
  end

  a_space_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !space_underflow);

  assign o_resp     = resp_q;
  assign o_nresp    = nresp_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_data  = wr_data_q;
  assign o_wr_sop   = wr_sop_q;
  assign o_wr_eop   = wr_eop_q;
  assign o_ready    = ready_q;
  assign o_ramspace = space_q;

endmodule

// File: tb/tb_port_resp_arb.sv
// Bench for port_resp_arb: packet-level reference model checked every cycle plus directed literals.
module tb_port_resp_arb;

  localparam int P  = 16;
  localparam int DW = 32;
  localparam int RW = 10;
  localparam int RB = 1023;
  localparam int TO = 64;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [P-1:0]  i_req;
  logic [P-1:0]  o_resp, o_nresp;
  logic [DW-1:0] i_data [P-1:0];
  logic [P-1:0]  i_data_vld, i_eop;
  logic          o_ready;
  logic [RW-1:0] o_ramspace;
  logic          o_wr_en, o_wr_sop, o_wr_eop;
  logic [DW-1:0] o_wr_data;
  logic          i_free_vld;
  logic [RW-1:0] i_free_blocks;
`ifdef PORT_RESP_TIMEOUT_EN
  logic          o_timeout;
`endif

  always #5 i_clk = ~i_clk;

  port_resp_arb dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
`ifdef PORT_RESP_TIMEOUT_EN
    .o_timeout     (o_timeout),
`endif
    .i_req         (i_req),
    .o_resp        (o_resp),
    .o_nresp       (o_nresp),
    .i_data        (i_data),
    .i_data_vld    (i_data_vld),
    .i_eop         (i_eop),
    .o_ready       (o_ready),
    .o_ramspace    (o_ramspace),
    .o_wr_en       (o_wr_en),
    .o_wr_data     (o_wr_data),
    .o_wr_sop      (o_wr_sop),
    .o_wr_eop      (o_wr_eop),
    .i_free_vld    (i_free_vld),
    .i_free_blocks (i_free_blocks)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a port is either free or owned by one channel; space is a clamped integer.
  bit            m_busy, m_hdr;
  int            m_ptr, m_sel, m_space, m_wait;
  logic [P-1:0]  e_resp, e_nresp;
  logic          e_wr_en, e_sop, e_eop, e_ready, e_tmo;
  logic [DW-1:0] e_data;

  always @(posedge i_clk or negedge i_rst_n) begin : model
    int res, w, len;
    if (!i_rst_n) begin
      m_busy = 0; m_hdr = 0; m_ptr = 0; m_sel = 0; m_space = RB; m_wait = 0;
      e_resp = '0; e_nresp = '0; e_wr_en = 0; e_sop = 0; e_eop = 0; e_tmo = 0;
      e_data = '0; e_ready = 1;
    end else begin
      res = 0;
      e_resp = '0; e_nresp = '0; e_wr_en = 0; e_sop = 0; e_eop = 0; e_tmo = 0;
      if (!m_busy) begin
        w = -1;
        for (int k = 0; k < P; k++)
          if (w < 0 && i_req[(m_ptr + k) % P]) w = (m_ptr + k) % P;
        if (w >= 0) begin
          e_resp  = P'(1) << w;
          e_nresp = i_req & ~e_resp;
          m_ptr   = (w + 1) % P;
          m_sel   = w;
          m_busy  = 1;
          m_hdr   = 0;
          m_wait  = 0;
        end
      end else begin
        e_nresp = i_req;
        if (i_data_vld[m_sel]) begin
          e_wr_en = 1;
          e_data  = i_data[m_sel];
          e_sop   = !m_hdr;
          if (!m_hdr) begin
            len = int'((i_data[m_sel] >> 7) & 32'h3FF);
            res = ((len + 4) / 64 + 1) % (1 << RW);
          end
          m_hdr = 1;
          if (i_eop[m_sel]) begin
            e_eop  = 1;
            m_busy = 0;
          end
        end
`ifdef PORT_RESP_TIMEOUT_EN
        else if (!m_hdr) begin
          m_wait++;
          if (m_wait == TO) begin
            e_tmo  = 1;
            m_busy = 0;
          end
        end
`endif
      end
      m_space = m_space - res + (i_free_vld ? int'(i_free_blocks) : 0);
      if (m_space < 0)  m_space = 0;
      if (m_space > RB) m_space = RB;
      e_ready = !m_busy && (m_space != 0);
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("resp",     32'(o_resp),     32'(e_resp));
      check("nresp",    32'(o_nresp),    32'(e_nresp));
      check("wr_en",    32'(o_wr_en),    32'(e_wr_en));
      check("wr_sop",   32'(o_wr_sop),   32'(e_sop));
      check("wr_eop",   32'(o_wr_eop),   32'(e_eop));
      check("ready",    32'(o_ready),    32'(e_ready));
      check("ramspace", 32'(o_ramspace), 32'(m_space));
      if (e_wr_en) check("wr_data", o_wr_data, e_data);
`ifdef PORT_RESP_TIMEOUT_EN
      check("timeout",  32'(o_timeout),  32'(e_tmo));
`endif
    end
  end

  function automatic logic [31:0] hdr(input int len);
    return (32'(len) << 7) | 32'h5A;
  endfunction

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic clear_in();
    i_req = '0; i_data_vld = '0; i_eop = '0; i_free_vld = 1'b0; i_free_blocks = '0;
  endtask

  task automatic beat(input int ch, input logic [31:0] d, input bit lst,
                      input bit fv = 1'b0, input int fb = 0);
    i_data_vld[ch] = 1'b1;
    i_data[ch]     = d;
    i_eop[ch]      = lst;
    i_free_vld     = fv;
    i_free_blocks  = RW'(fb);
    tick();
    clear_in();
  endtask

  task automatic grant(input logic [P-1:0] req, input logic [P-1:0] exp_resp, input string nm);
    i_req = req;
    tick();
    check(nm, 32'(o_resp), 32'(exp_resp));
    clear_in();
  endtask

  task automatic do_reset();
    #2 i_rst_n = 1'b0;
    tick();
    tick();
    #2 i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < P; i++) i_data[i] = '0;
    clear_in();
    i_rst_n = 1'b0;
    repeat (3) tick();
    check("rst_resp",  32'(o_resp),     32'h0);
    check("rst_ready", 32'(o_ready),    32'h1);
    check("rst_space", 32'(o_ramspace), 32'd1023);
    check("rst_wr_en", 32'(o_wr_en),    32'h0);
    #2 i_rst_n = 1'b1;
    cmp_en = 1'b1;

    // Single request, 3-beat packet, len 100 reserves 2 blocks
    grant(16'h0004, 16'h0004, "t1_resp");
    check("t1_ready_busy", 32'(o_ready), 32'h0);
    beat(2, hdr(100), 1'b0);
    check("t1_sop",   32'(o_wr_sop),   32'h1);
    check("t1_space", 32'(o_ramspace), 32'd1021);
    beat(2, 32'hA1, 1'b0);
    beat(2, 32'hA2, 1'b1);
    check("t1_eop",   32'(o_wr_eop),  32'h1);
    check("t1_data",  o_wr_data,      32'hA2);
    check("t1_ready", 32'(o_ready),   32'h1);

    // Contest between channels 0 and 4, then rotation
    do_reset();
    i_req = 16'h0011;
    tick();
    check("t2_resp",  32'(o_resp),  32'h0001);
    check("t2_nresp", 32'(o_nresp), 32'h0010);
    clear_in();
    beat(0, hdr(0), 1'b1);
    grant(16'h0011, 16'h0010, "t2_resp_rr");
    beat(4, hdr(0), 1'b1);

    // Pointer at 5 wraps to channel 1; ch7 rejected mid-stream; request on final beat rejected
    grant(16'h0002, 16'h0002, "t3_resp_wrap");
    beat(1, hdr(64), 1'b0);
    i_req = 16'h0080;
    beat(1, 32'hB1, 1'b0);
    check("t3_nresp", 32'(o_nresp), 32'h0080);
    check("t3_resp0", 32'(o_resp),  32'h0);
    check("t3_wr_en", 32'(o_wr_en), 32'h1);
    i_req = 16'h0008;
    beat(1, 32'hB2, 1'b1);
    check("t3_last_nresp", 32'(o_nresp), 32'h0008);
    check("t3_last_eop",   32'(o_wr_eop), 32'h1);

    // Space arithmetic: 1023-17-6 = 1000; -3+5 = 1002; +18 = 1020; +10 saturates
    do_reset();
    grant(16'h0001, 16'h0001, "t4_g1");
    beat(0, hdr(1023), 1'b1);
    grant(16'h0001, 16'h0001, "t4_g2");
    beat(0, hdr(320), 1'b1);
    check("t4_space1000", 32'(o_ramspace), 32'd1000);
    grant(16'h0001, 16'h0001, "t4_g3");
    beat(0, hdr(150), 1'b1, 1'b1, 5);
    check("t4_space1002", 32'(o_ramspace), 32'd1002);
    i_free_vld = 1'b1; i_free_blocks = RW'(18);
    tick();
    clear_in();
    check("t4_space1020", 32'(o_ramspace), 32'd1020);
    i_free_vld = 1'b1; i_free_blocks = RW'(10);
    tick();
    clear_in();
    check("t4_sat", 32'(o_ramspace), 32'd1023);

    // Reset in the middle of a payload
    grant(16'h0001, 16'h0001, "t5_g");
    beat(0, hdr(100), 1'b0);
    beat(0, 32'hC1, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    check("t5_wr_en", 32'(o_wr_en),    32'h0);
    check("t5_eop",   32'(o_wr_eop),   32'h0);
    check("t5_space", 32'(o_ramspace), 32'd1023);
    tick();
    #2 i_rst_n = 1'b1;
    tick();
    check("t5_ready", 32'(o_ready), 32'h1);
    grant(16'h0003, 16'h0001, "t5_ptr_reset");
    beat(0, hdr(0), 1'b1);

`ifdef PORT_RESP_TIMEOUT_EN
    grant(16'h0002, 16'h0002, "t6_g");
    repeat (TO - 1) tick();
    check("t6_no_tmo_yet", 32'(o_timeout), 32'h0);
    tick();
    check("t6_tmo",   32'(o_timeout),  32'h1);
    check("t6_space", 32'(o_ramspace), 32'd1023);
    tick();
    check("t6_ready", 32'(o_ready), 32'h1);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/port_resp_arb.md
Name: port_resp_arb

Overview:
- Output-port responder: the far end of the channel request/response/data protocol.
- One instance per output port. It receives one-cycle request pulses from all PORTNUM input channels and grants exactly one with a one-cycle o_resp pulse. All other requesters receive a one-cycle o_nresp pulse.
- It then accepts the winner's packet stream and forwards it to the port's cache write interface.
- It tracks free RAM blocks and advertises them as o_ramspace/o_ready back to the channels.

Parameters:
- PORTNUM, 16, number of input channels.
- DWIDTH, 32, data word width.
- RAMWIDTH, 10, width of the free-block counter.
- RAM_BLOCKS, 1023, total 64-byte blocks; the reset value of o_ramspace. Must satisfy RAM_BLOCKS < 2**RAMWIDTH.
- TIMEOUT, 64, cycles allowed from grant to first data beat (used only with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  PORTNUM  one-cycle request pulses, one bit per channel.
- o_resp  out  PORTNUM  one-hot grant pulse.
- o_nresp  out  PORTNUM  reject pulses.
- i_data  in  DWIDTH x [PORTNUM-1:0] (unpacked)  per-channel data.
- i_data_vld  in  PORTNUM  per-channel beat valid.
- i_eop  in  PORTNUM  per-channel last beat.
- o_ready  out  1  port idle and able to accept a request.
- o_ramspace  out  RAMWIDTH  free 64-byte blocks.
- o_wr_en  out  1  cache write strobe.
- o_wr_data  out  DWIDTH  cache write data.
- o_wr_sop  out  1  first beat (header) of packet.
- o_wr_eop  out  1  last beat of packet.
- i_free_vld  in  1  downstream has released blocks.
- i_free_blocks  in  RAMWIDTH  number of blocks released.

Behaviour:
- Reset values: every output 0, except o_ramspace = RAM_BLOCKS and o_ready = 1. State = S_IDLE. Round-robin pointer = 0.
- S_IDLE:
  - If i_req != 0: the winner is the first set bit at or after the RR pointer, with wrap.
  - Next cycle: o_resp = 1 << winner, o_nresp = i_req & ~o_resp. Both are single-cycle. Go to S_WAIT_SOP.
  - The RR pointer becomes winner+1 modulo PORTNUM.
- Busy (any state other than S_IDLE): o_ready = 0. Any i_req bit gets an o_nresp pulse on the next cycle. o_resp stays 0.
- S_WAIT_SOP: the first i_data_vld[sel] beat is the header.
  - Registered write: o_wr_en=1, o_wr_sop=1, o_wr_data = i_data[sel].
  - Reserve blocks = ((hdr[16:7] + 11'd4) >> 6) + 1, computed in 11 bits and then truncated to RAMWIDTH.
  - Go to S_RECV. If i_eop[sel] is also set on this beat, o_wr_eop=1 and go to S_IDLE.
- S_RECV: each i_data_vld[sel] beat produces one registered write (one cycle latency). The beat carrying i_eop[sel] sets o_wr_eop=1 and returns to S_IDLE.
- Beats from non-selected channels are ignored.
- o_ready:
  - Registered; 1 in the cycle after returning to S_IDLE.
  - Also 0 whenever o_ramspace == 0.
- o_ramspace update: next = cur − reserve (on header beat) + i_free_blocks (when i_free_vld).
  - Both events in the same cycle apply the net result in one update.
  - Computed in RAMWIDTH+1 bits. Saturates at RAM_BLOCKS high and at 0 low.
  - Underflow also raises an assertion-only error (simulation check).
- Reset mid-packet: return immediately to S_IDLE and restore o_ramspace to RAM_BLOCKS. No o_wr_eop is emitted for the truncated packet.
- Simultaneous i_req in the same cycle as the return to S_IDLE: the request is rejected (state was still busy).

Optional Feature:
- Macro: PORT_RESP_TIMEOUT_EN.
- Defined: a counter starts at grant. If no header beat arrives within TIMEOUT cycles of S_WAIT_SOP:
  - Return to S_IDLE with no write and no reservation.
  - Pulse o_timeout for one cycle. o_timeout is an extra 1-bit output that exists only under the macro.
- Undefined: S_WAIT_SOP waits indefinitely. No counter and no o_timeout port.

Decomposition:
- Package port_cache_pkg:
  - State enum (S_IDLE, S_WAIT_SOP, S_RECV).
  - BLOCK_BYTES=64.
  - HDR_LEN_MSB=16 and HDR_LEN_LSB=7.
  - Function blocks_needed(len).
- Sub-module rr_arb16: round-robin one-hot picker with pointer update on grant. Shared with future output arbiters.

Test Plan:
- Single request, i_req=16'h0004, 3-beat packet with header len=100 → o_resp=16'h0004 one cycle later. 3 o_wr_en beats; sop on first, eop on third. o_ramspace 1023→1021.
- Simultaneous i_req=16'h0011 from reset → o_resp=16'h0001, o_nresp=16'h0010. On the next contest, i_req=16'h0011 again → o_resp=16'h0010.
- Request from channel 7 while receiving → o_nresp=16'h0080 next cycle, o_resp=0, write stream uninterrupted.
- Header reserving 3 blocks in the same cycle as i_free_vld with i_free_blocks=5, starting from 1000 → 1002. Free of 10 at 1020 → saturates at 1023.
- Assert i_rst_n=0 mid-S_RECV → all outputs to reset values, o_ramspace=1023, o_ready=1 after release.
- With PORT_RESP_TIMEOUT_EN: grant, then no data for 64 cycles → o_timeout pulse, state S_IDLE, o_ramspace unchanged.
